// File: rtl/display_scan_driver.sv
// display_scan_driver
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Digits 3:0 show a 16-bit value in hex, digit 7 shows a 3-bit status,
// DPs 4:0 show flags. Inputs are captured once per scan frame so a frame
// is always internally consistent.
module display_scan_driver #(
  parameter int DWELL = 100000,
  parameter int CNT_W = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ToDisplay,
  input  logic [4:0]  Flags,
  input  logic [2:0]  Status,
  input  logic        BlankZeros,
  output logic [7:0]  Anodes,
  output logic [6:0]  Segments,
  output logic        DP
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             dwell_done;

  logic [15:0] frame_value;
  logic [4:0]  frame_flags;
  logic [2:0]  frame_status;
  logic        frame_blank;

  logic [6:0]  seg_next;
  logic        dp_lit;
  logic [7:0]  an_next;

  // Active-low hex patterns, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign dwell_done = (cnt == CNT_LAST);

  // Dwell counter and digit index; index advances once per dwell period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (dwell_done) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame snapshot at the very end of digit 7 so the next frame starts fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_value  <= 16'h0000;
      frame_flags  <= 5'b00000;
      frame_status <= 3'd0;
      frame_blank  <= 1'b0;
    end else if (dwell_done && (idx == 3'd7)) begin
      frame_value  <= ToDisplay;
      frame_flags  <= Flags;
      frame_status <= Status;
      frame_blank  <= BlankZeros;
    end
  end

  // Per-digit content from the current index and frame registers only
  always_comb begin
    seg_next = 7'h7F;
    dp_lit   = 1'b0;
    case (idx)
      3'd0: begin
        seg_next = hex7(frame_value[3:0]);
        dp_lit   = frame_flags[0];
      end
      3'd1: begin
        seg_next = (frame_blank && (frame_value[15:4] == 12'h000)) ?
                   7'h7F : hex7(frame_value[7:4]);
        dp_lit   = frame_flags[1];
      end
      3'd2: begin
        seg_next = (frame_blank && (frame_value[15:8] == 8'h00)) ?
                   7'h7F : hex7(frame_value[11:8]);
        dp_lit   = frame_flags[2];
      end
      3'd3: begin
        seg_next = (frame_blank && (frame_value[15:12] == 4'h0)) ?
                   7'h7F : hex7(frame_value[15:12]);
        dp_lit   = frame_flags[3];
      end
      3'd4: begin
        dp_lit   = frame_flags[4];
      end
      3'd7: begin
        seg_next = hex7({1'b0, frame_status});
      end
      default: begin
        seg_next = 7'h7F;
        dp_lit   = 1'b0;
      end
    endcase
    // A digit with nothing to show keeps its anode off
    an_next = ((seg_next != 7'h7F) || dp_lit) ? ~(8'd1 << idx) : 8'hFF;
  end

  // Registered outputs; anode, segments and DP always come from the same slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Anodes   <= 8'hFF;
      Segments <= 7'h7F;
      DP       <= 1'b1;
    end else begin
      Anodes   <= an_next;
      Segments <= seg_next;
      DP       <= ~dp_lit;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver with a short dwell. Expected frames are
// queued by the stimulus process; a monitor checks every output cycle.
module tb_display_scan_driver;

  localparam int DWELL = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ToDisplay;
  logic [4:0]  Flags;
  logic [2:0]  Status;
  logic        BlankZeros;
  logic [7:0]  Anodes;
  logic [6:0]  Segments;
  logic        DP;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         frame;
    int         digit;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   run   = 1'b0;

  display_scan_driver #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ToDisplay  (ToDisplay),
    .Flags      (Flags),
    .Status     (Status),
    .BlankZeros (BlankZeros),
    .Anodes     (Anodes),
    .Segments   (Segments),
    .DP         (DP)
  );

  always #5 clk = ~clk;

  // Hand-computed segment bytes per frame, digit 7 in the top byte
  function automatic logic [63:0] seg_row(input int f);
    case (f)
      0: return 64'h40_7F_7F_7F_40_40_40_40;
      1: return 64'h30_7F_7F_7F_79_08_30_0E;
      2: return 64'h40_7F_7F_7F_7F_7F_7F_12;
      3: return 64'h40_7F_7F_7F_7F_7F_7F_40;
      4: return 64'h40_7F_7F_7F_7F_7F_7F_12;
      5: return 64'h78_7F_7F_7F_79_79_79_79;
      6: return 64'h12_7F_7F_7F_24_24_24_24;
      7: return 64'h40_7F_7F_7F_7F_79_40_40;
      8: return 64'h02_7F_7F_7F_03_06_00_0E;
      default: return 64'h24_7F_7F_7F_19_21_10_46;
    endcase
  endfunction

  // Digits whose DP is expected lit in each frame
  function automatic logic [7:0] dp_row(input int f);
    case (f)
      4: return 8'h11;
      6: return 8'h0E;
      7: return 8'h04;
      9: return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  task automatic apply(input int f);
    case (f)
      1: begin ToDisplay = 16'h1A3F; Flags = 5'b00000; Status = 3'd3; BlankZeros = 1'b0; end
      2: begin ToDisplay = 16'h0005; Flags = 5'b00000; Status = 3'd0; BlankZeros = 1'b1; end
      3: begin ToDisplay = 16'h0000; Flags = 5'b00000; Status = 3'd0; BlankZeros = 1'b1; end
      4: begin ToDisplay = 16'h0005; Flags = 5'b10001; Status = 3'd0; BlankZeros = 1'b1; end
      5: begin ToDisplay = 16'h1111; Flags = 5'b00000; Status = 3'd7; BlankZeros = 1'b0; end
      6: begin ToDisplay = 16'h2222; Flags = 5'b01110; Status = 3'd5; BlankZeros = 1'b0; end
      7: begin ToDisplay = 16'h0100; Flags = 5'b00100; Status = 3'd0; BlankZeros = 1'b1; end
      8: begin ToDisplay = 16'hBE8F; Flags = 5'b00000; Status = 3'd6; BlankZeros = 1'b1; end
      default: begin ToDisplay = 16'h4D9C; Flags = 5'b10000; Status = 3'd2; BlankZeros = 1'b0; end
    endcase
  endtask

  task automatic push_frame(input int f);
    logic [63:0] row;
    logic [7:0]  dpm;
    exp_t        e;
    row = seg_row(f);
    dpm = dp_row(f);
    for (int k = 0; k < 8; k++) begin
      e.seg   = row[8*k +: 7];
      e.dp    = ~dpm[k];
      e.an    = ((e.seg == 7'h7F) && !dpm[k]) ? 8'hFF : ~(8'd1 << k);
      e.frame = f;
      e.digit = k;
      q.push_back(e);
    end
  endtask

  task automatic cmp(input string name, input logic [7:0] an,
                     input logic [6:0] seg, input logic dp);
    n_cmp++;
    if (Anodes !== an || Segments !== seg || DP !== dp) begin
      n_bad++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
               name, Anodes, Segments, DP, an, seg, dp);
    end
  endtask

  // Monitor: every output cycle is checked against the head slot
  initial begin
    int sub;
    sub = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!run) begin
        sub = 0;
      end else if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL queue_empty: got 0 entries, expected at least 1");
      end else begin
        cmp($sformatf("f%0d_d%0d_c%0d", q[0].frame, q[0].digit, sub),
            q[0].an, q[0].seg, q[0].dp);
        sub++;
        if (sub == DWELL) begin
          sub = 0;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus: inputs for frame f are applied while frame f-1 shows digit 1
  initial begin
    reset      = 1'b1;
    ToDisplay  = 16'hFFFF;
    Flags      = 5'b11111;
    Status     = 3'd7;
    BlankZeros = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_hold", 8'hFF, 7'h7F, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    push_frame(0);
    run = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int f = 1; f <= 9; f++) begin
      apply(f);
      push_frame(f);
      repeat (32) @(negedge clk);
    end
    // Now in frame 9, digit 1 slot; move to where index is 5 and digit 4 still shows
    repeat (15) @(negedge clk);
    run   = 1'b0;
    reset = 1'b1;
    #1;
    cmp("reset_async", 8'hFF, 7'h7F, 1'b1);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_mid_hold", 8'hFF, 7'h7F, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    push_frame(0);
    run = 1'b1;
    repeat (32) @(negedge clk);
    run = 1'b0;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drained: got %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
